// File: rtl/shared_unit_responder_pkg.sv
// Shared definitions for the 4-request round-robin path: state encoding and one-hot helpers.
// The arbiter bench also uses onehot_valid.
package rr_pkg;
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
  function automatic logic onehot_valid(input logic [NUM_REQ-1:0] oh);
    return (oh != '0) && ((oh & (oh - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/shared_unit_responder_if.sv
// Grant/operand/completion bundle between the arbiter side (master) and the responder (slave).
interface shared_unit_responder_if #(parameter int DATA_W = 8);
  import rr_pkg::*;

  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic                      ready;
  logic                      busy;
  logic [NUM_REQ-1:0]        req_mask;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         dout;
  logic                      err;
  logic [7:0]                drop_cnt;

  modport master (output gnt, din,
                  input  ready, busy, req_mask, done, dout, err, drop_cnt);
  modport slave  (input  gnt, din,
                  output ready, busy, req_mask, done, dout, err, drop_cnt);
endinterface

// File: rtl/shared_unit_responder_onehot_encode.sv
// Combinational 4-bit one-hot to 2-bit index with an exactly-one-set flag. Zero latency.
module onehot_encode
  import rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [1:0]         idx,
  output logic               valid
);
  assign idx   = onehot_idx(onehot);
  assign valid = onehot_valid(onehot);
endmodule

// File: rtl/shared_unit_responder.sv
// Shared execution unit behind the arbiter grant: result = operand+1, done pulse LAT edges after accept.
// Grants arriving while BUSY, or multi-hot grants, are discarded and counted; ready is low in BUSY.
module shared_unit_responder
  import rr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LAT    = 3
)(
  input  logic                    Clk,
  input  logic                    Rst,
  shared_unit_responder_if.slave  bus
);
  localparam int CW = $clog2(LAT + 1);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [1:0]          gnt_idx;
  logic [1:0]          idx;
  logic                gnt_ok;
  logic                any_gnt;
  logic                accept;
  logic                finish;
  logic [DATA_W-1:0]   operand;

  onehot_encode u_enc (
    .onehot (bus.gnt),
    .idx    (gnt_idx),
    .valid  (gnt_ok)
  );

  assign any_gnt  = |bus.gnt;
  assign bus.ready = (state != BUSY);
  assign bus.busy  = (state == BUSY);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_ok) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // Back-to-back issue: a clean grant in the DONE cycle goes straight to BUSY.
        if (gnt_ok) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt          <= '0;
      idx          <= '0;
      operand      <= '0;
      bus.req_mask <= '0;
      bus.done     <= '0;
      bus.dout     <= '0;
      bus.err      <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      bus.err  <= any_gnt && !gnt_ok;
      bus.done <= '0;
      if (any_gnt && !accept && (bus.drop_cnt != 8'hFF))
        bus.drop_cnt <= bus.drop_cnt + 8'd1;
      if (accept) begin
        idx          <= gnt_idx;
        operand      <= bus.din[gnt_idx*DATA_W +: DATA_W];
        cnt          <= CW'(LAT - 1);
        bus.req_mask <= bus.gnt;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        bus.done     <= NUM_REQ'(1) << idx;
        bus.dout     <= operand + 1'b1;
        bus.req_mask <= '0;
      end
    end
  end
endmodule

// File: tb/tb_shared_unit_responder.sv
// Directed and randomized checks of shared_unit_responder (LAT=3 and LAT=15 instances) against a transaction-level model.
module tb_shared_unit_responder;
  import rr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_unit_responder_if #(.DATA_W(8)) if3 ();
  shared_unit_responder_if #(.DATA_W(8)) if15 ();

  shared_unit_responder #(.DATA_W(8), .LAT(3))  u3  (.Clk(clk), .Rst(rst), .bus(if3));
  shared_unit_responder #(.DATA_W(8), .LAT(15)) u15 (.Clk(clk), .Rst(rst), .bus(if15));

  int errors = 0;
  int checks = 0;

  // Model: rem = edges still to go before the result appears (0 = unit free).
  int         rem    [2];
  int         own    [2];
  int         m_drop [2];
  logic [7:0] m_op   [2];
  logic [7:0] m_dout [2];
  logic [3:0] m_mask [2];
  logic [3:0] m_done [2];
  logic       m_err  [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : 15;
  endfunction

  task automatic model_step(input int k, input logic r, input logic [3:0] g, input logic [31:0] d);
    int ones;
    bit acc;
    if (r) begin
      rem[k] = 0; own[k] = 0; m_drop[k] = 0; m_op[k] = 8'h00; m_dout[k] = 8'h00;
      m_mask[k] = 4'h0; m_done[k] = 4'h0; m_err[k] = 1'b0;
    end else begin
      ones     = $countones(g);
      acc      = (rem[k] == 0) && (ones == 1);
      m_err[k] = (ones > 1);
      if ((g != 4'h0) && !acc && (m_drop[k] < 255)) m_drop[k] = m_drop[k] + 1;
      m_done[k] = 4'h0;
      if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
        if (rem[k] == 0) begin
          m_done[k] = 4'b0001 << own[k];
          m_dout[k] = m_op[k] + 8'd1;
          m_mask[k] = 4'h0;
        end
      end
      if (acc) begin
        own[k]    = $clog2(g);
        m_op[k]   = d[own[k]*8 +: 8];
        rem[k]    = lat_of(k);
        m_mask[k] = g;
      end
    end
  endtask

  function automatic logic [26:0] exp_vec(input int k);
    return {rem[k] == 0, rem[k] != 0, m_mask[k], m_done[k], m_dout[k], m_err[k], 8'(m_drop[k])};
  endfunction

  // Drive one cycle of inputs to both instances, advance the model on the edge, sample 1 time unit later.
  task automatic tick(input logic r, input logic [3:0] g, input logic [31:0] d);
    rst = r;
    if3.gnt = g;  if3.din = d;
    if15.gnt = g; if15.din = d;
    @(posedge clk);
    model_step(0, r, g, d);
    model_step(1, r, g, d);
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, 4'h0, 32'h0);
    tick(1'b1, 4'hF, 32'hFFFF_FFFF);
    checks++;
    if ({if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt} !== {1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: got ready=%b busy=%b mask=%b done=%b dout=%h err=%b drop=%0d, want 1 0 0000 0000 00 0 0",
               if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt);
    end
  endtask

  task automatic test_single;
    tick(1'b0, 4'b0010, 32'h0000_4100);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({if3.busy, if3.ready, if3.req_mask, if3.done} !== {1'b1, 1'b0, 4'b0010, 4'b0000}) begin
        errors++;
        $display("FAIL single_busy cyc%0d: got busy=%b ready=%b mask=%b done=%b, want 1 0 0010 0000",
                 c, if3.busy, if3.ready, if3.req_mask, if3.done);
      end
      if (c < 2) tick(1'b0, 4'h0, 32'h0);
    end
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.done, if3.dout, if3.busy, if3.ready, if3.req_mask} !== {4'b0010, 8'h42, 1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL single_done: got done=%b dout=%h busy=%b ready=%b mask=%b, want 0010 42 0 1 0000",
               if3.done, if3.dout, if3.busy, if3.ready, if3.req_mask);
    end
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.done, if3.dout} !== {4'b0000, 8'h42}) begin
      errors++;
      $display("FAIL single_hold: got done=%b dout=%h, want 0000 42", if3.done, if3.dout);
    end
  endtask

  task automatic test_back_to_back;
    tick(1'b0, 4'b0001, 32'h0000_00FF);
    tick(1'b0, 4'h0, 32'h0);
    tick(1'b0, 4'h0, 32'h0);
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.done, if3.dout} !== {4'b0001, 8'h00}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b dout=%h, want 0001 00", if3.done, if3.dout);
    end
    tick(1'b0, 4'b1000, 32'h1000_0000);
    checks++;
    if ({if3.busy, if3.req_mask, if3.done} !== {1'b1, 4'b1000, 4'b0000}) begin
      errors++;
      $display("FAIL b2b_reissue: got busy=%b mask=%b done=%b, want 1 1000 0000", if3.busy, if3.req_mask, if3.done);
    end
    tick(1'b0, 4'h0, 32'hAAAA_AAAA);
    tick(1'b0, 4'h0, 32'h0);
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.done, if3.dout, if3.drop_cnt} !== {4'b1000, 8'h11, 8'd0}) begin
      errors++;
      $display("FAIL b2b_second: got done=%b dout=%h drop=%0d, want 1000 11 0", if3.done, if3.dout, if3.drop_cnt);
    end
  endtask

  task automatic test_collision;
    logic [7:0] v;
    v = 8'($urandom);
    tick(1'b1, 4'h0, 32'h0);
    tick(1'b0, 4'b0100, {8'h00, v, 16'h0000});
    tick(1'b0, 4'b0001, 32'h0000_0077);
    tick(1'b0, 4'b0001, 32'h0000_0077);
    checks++;
    if ({if3.drop_cnt, if3.err, if3.req_mask} !== {8'd2, 1'b0, 4'b0100}) begin
      errors++;
      $display("FAIL collision_drop: got drop=%0d err=%b mask=%b, want 2 0 0100", if3.drop_cnt, if3.err, if3.req_mask);
    end
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.done, if3.dout, if3.drop_cnt} !== {4'b0100, v + 8'd1, 8'd2}) begin
      errors++;
      $display("FAIL collision_done: got done=%b dout=%h drop=%0d, want 0100 %h 2", if3.done, if3.dout, if3.drop_cnt, v + 8'd1);
    end
  endtask

  task automatic test_malformed;
    tick(1'b1, 4'h0, 32'h0);
    tick(1'b0, 4'b0110, 32'h1234_5678);
    checks++;
    if ({if3.err, if3.drop_cnt, if3.ready, if3.busy, if3.req_mask} !== {1'b1, 8'd1, 1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL malformed: got err=%b drop=%0d ready=%b busy=%b mask=%b, want 1 1 1 0 0000",
               if3.err, if3.drop_cnt, if3.ready, if3.busy, if3.req_mask);
    end
    tick(1'b0, 4'h0, 32'h0);
    checks++;
    if ({if3.err, if3.drop_cnt, if3.ready} !== {1'b0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL malformed_after: got err=%b drop=%0d ready=%b, want 0 1 1", if3.err, if3.drop_cnt, if3.ready);
    end
  endtask

  task automatic test_reset_midop;
    bit seen;
    tick(1'b1, 4'h0, 32'h0);
    tick(1'b0, 4'b0010, 32'h0000_5500);
    tick(1'b0, 4'h0, 32'h0);
    tick(1'b1, 4'h0, 32'h0);
    checks++;
    if ({if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt} !== {1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_midop: got ready=%b busy=%b mask=%b done=%b dout=%h err=%b drop=%0d, want 1 0 0000 0000 00 0 0",
               if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 4'h0, 32'h0);
      if (if3.done != 4'h0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got a done pulse after abort, want none");
    end
  endtask

  task automatic test_saturation;
    tick(1'b1, 4'h0, 32'h0);
    for (int c = 0; c < 300; c++) tick(1'b0, 4'b0010, $urandom);
    checks++;
    if (if15.drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation: got drop=%0d, want 255", if15.drop_cnt);
    end
    checks++;
    if (if3.drop_cnt !== 8'(m_drop[0])) begin
      errors++;
      $display("FAIL saturation_lat3: got drop=%0d, want %0d", if3.drop_cnt, m_drop[0]);
    end
  endtask

  task automatic test_random;
    logic [3:0] g;
    logic       r;
    int         sel;
    tick(1'b1, 4'h0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      sel = $urandom_range(0, 7);
      if (sel < 4)      g = 4'h0;
      else if (sel < 6) g = 4'b0001 << $urandom_range(0, 3);
      else              g = 4'($urandom);
      r = ($urandom_range(0, 63) == 0);
      tick(r, g, $urandom);
      checks++;
      if ({if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt} !== exp_vec(0)) begin
        errors++;
        $display("FAIL random_lat3 cyc%0d: got %h, want %h", c,
                 {if3.ready, if3.busy, if3.req_mask, if3.done, if3.dout, if3.err, if3.drop_cnt}, exp_vec(0));
      end
      checks++;
      if ({if15.ready, if15.busy, if15.req_mask, if15.done, if15.dout, if15.err, if15.drop_cnt} !== exp_vec(1)) begin
        errors++;
        $display("FAIL random_lat15 cyc%0d: got %h, want %h", c,
                 {if15.ready, if15.busy, if15.req_mask, if15.done, if15.dout, if15.err, if15.drop_cnt}, exp_vec(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if3.gnt = 4'h0;  if3.din = 32'h0;
    if15.gnt = 4'h0; if15.din = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_malformed();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_unit_responder.md
# shared_unit_responder

Completion side of the 4-request round-robin arbitration path. It sits behind the arbiter's registered one-hot `gnt` and owns one shared multi-cycle execution unit. It captures the granted requester's operand and holds off that port while the operation is in flight. On completion it returns the result with a one-cycle `done` pulse steered to the originating port.

## Interface
Parameters:
- `DATA_W`, 8: operand/result width.
- `LAT`, 3: execution cycles in BUSY; legal range 1..15.

Ports:
- `Clk`, in, 1: single clock; all state updates on posedge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `gnt`, in, 4: one-hot grant from the arbiter; 0 = no grant.
- `din`, in, 4*DATA_W: operands, port i at `din[i*DATA_W +: DATA_W]`.
- `ready`, out, 1: unit can accept a grant this cycle.
- `busy`, out, 1: operation in execution (state BUSY).
- `req_mask`, out, 4: one-hot of the port in service; requesters must deassert `req` while their bit is set.
- `done`, out, 4: one-cycle one-hot completion pulse to the owning port.
- `dout`, out, DATA_W: result; valid only while `done != 0`.
- `err`, out, 1: one-cycle pulse when a malformed (multi-hot) grant is sampled.
- `drop_cnt`, out, 8: saturating count of grants discarded.

## Operation
- FSM states: IDLE, BUSY, DONE. Encodings live in the shared package.
- Accept condition: state is IDLE or DONE, and `gnt` has exactly one bit set. On accept:
  - latch port index `idx` and operand `din[idx]`;
  - load `cnt = LAT-1`;
  - set `req_mask = gnt`;
  - go to BUSY.
- IDLE with `gnt == 0`: stay in IDLE.
- BUSY:
  - `cnt > 0`: decrement.
  - `cnt == 0`: compute `result = operand + 1` (mod 2^DATA_W), set `done[idx] = 1` and `dout = result`, clear `req_mask`, go to DONE.
- DONE lasts one cycle. Next state is BUSY if a grant is accepted that cycle, otherwise IDLE. This allows back-to-back operations.
- Any nonzero `gnt` sampled in BUSY is discarded. `drop_cnt` increments, saturating at 255, and there is no other effect.
- Multi-hot `gnt` in any state:
  - `err` pulses;
  - `drop_cnt` increments;
  - state does not change, except that DONE still falls to IDLE.
- `ready = (state != BUSY)`.
- `busy = (state == BUSY)`.

## Timing
- Reset value of every output: `ready = 1`, `busy = 0`, `req_mask = 0`, `done = 0`, `dout = 0`, `err = 0`, `drop_cnt = 0`. `Rst` overrides every other input on the same edge.
- Grant accepted at edge N:
  - `busy` and `req_mask` are visible after edge N;
  - `done` and `dout` are visible for exactly the cycle after edge N+LAT;
  - `busy` is low in that DONE cycle.
- Latency from accepting edge to done-visible edge is LAT. Minimum issue interval is LAT+1 cycles (back-to-back via DONE).
- `dout` holds its last value when `done == 0`. It is cleared only by reset.
- `Rst` asserted mid-BUSY aborts the operation: no `done` is produced and `req_mask` is cleared on that edge.
- `din` is sampled only on the accepting edge. Later changes do not affect the result.
- Overflow: operand `2^DATA_W - 1` produces `dout = 0`. There is no carry output.
- `err` and `drop_cnt` update on the same edge the offending `gnt` is sampled.

## Structure
- Shared package `rr_pkg`:
  - NUM_REQ = 4;
  - FSM state typedef (IDLE/BUSY/DONE);
  - one-hot-to-index function;
  - one-hot-validity function (the arbiter bench reuses it).
- Sub-module `onehot_encode`: 4-bit one-hot to 2-bit index plus `valid` flag (exactly one bit set). It is combinational and instantiated once.
- Everything else lives in `shared_unit_responder`:
  - FSM;
  - latency counter of `$clog2(LAT+1)` bits;
  - operand/index registers;
  - drop counter.

## Test plan
- Single op, DATA_W=8, LAT=3: `gnt = 0010` with `din[1] = 8'h41` at edge 1 → `busy` high in cycles 2–4, then `done = 0010` and `dout = 8'h42` only in the cycle after edge 4; `ready` low in cycles 2–4.
- Back-to-back: `gnt = 0001` (`din[0] = 8'hFF`) at edge 1, `gnt = 1000` (`din[3] = 8'h10`) held during DONE at edge 5 → `dout = 8'h00` with `done = 0001`, then `dout = 8'h11` with `done = 1000` four cycles later.
- Collision: `gnt = 0100` accepted, then `gnt = 0001` presented for 2 BUSY cycles → `drop_cnt = 2`, no `err`, and the `done` pulse is for port 2 only.
- Malformed grant: `gnt = 0110` in IDLE → `err` pulses once, `drop_cnt = 1`, state stays IDLE and `ready` stays 1.
- Reset mid-op: `Rst` asserted during the second BUSY cycle → all outputs return to reset values next cycle, and no `done` pulse ever appears.
- Saturation: 300 `gnt = 0010` cycles during repeated BUSY with a long LAT=15 → `drop_cnt` stops at 255.
